// File: rtl/exe_issue.sv
// exe_issue: two-entry skid buffer between decode and the ALU.
// Define EXE_ISSUE_FWD_EN to snoop the writeback bus into buffered operands.
package alufnt;
  typedef enum logic [2:0] {
    add  = 3'd0,
    sub  = 3'd1,
    sll  = 3'd2,
    srl  = 3'd3,
    sra  = 3'd4,
    bxor = 3'd5,
    bor  = 3'd6,
    band = 3'd7
  } alu_func_t;
endpackage

module exe_issue
  import alufnt::*;
#(
  parameter int REGIDX_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  alu_func_t           in_fn,
  input  logic [REGIDX_W-1:0] in_rs1_idx,
  input  logic [REGIDX_W-1:0] in_rs2_idx,
  input  logic [31:0]         in_rs1_val,
  input  logic [31:0]         in_rs2_val,
  input  logic                in_use_imm,
  input  logic [31:0]         in_imm,
  input  logic [REGIDX_W-1:0] in_rd_idx,
  input  logic                wb_valid,
  input  logic [REGIDX_W-1:0] wb_rd_idx,
  input  logic [31:0]         wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output alu_func_t           fn,
  output logic [31:0]         in1,
  output logic [31:0]         in2,
  output logic [REGIDX_W-1:0] rd_idx
);

  typedef struct packed {
    logic                v;
    alu_func_t           fn;
    logic [REGIDX_W-1:0] rs1_idx;
    logic [REGIDX_W-1:0] rs2_idx;
    logic [31:0]         rs1_val;
    logic [31:0]         rs2_val;
    logic                use_imm;
    logic [31:0]         imm;
    logic [REGIDX_W-1:0] rd_idx;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t new_op;
  ent_t main_s, skid_s;
  logic acc;
  logic emit;

`ifdef EXE_ISSUE_FWD_EN
  function automatic ent_t snoop(
    input ent_t                e,
    input logic                wv,
    input logic [REGIDX_W-1:0] widx,
    input logic [31:0]         wdat
  );
    ent_t r;
    r = e;
    // x0 is never forwarded; its captured zero stays put
    if (wv && r.v && (widx != '0)) begin
      if (r.rs1_idx == widx) r.rs1_val = wdat;
      if (r.rs2_idx == widx) r.rs2_val = wdat;
    end
    return r;
  endfunction
`else
  logic unused_ok;
  assign unused_ok = ^{wb_valid, wb_rd_idx, wb_data,
                       main_q.rs1_idx, main_q.rs2_idx};
`endif

  assign acc  = in_valid && in_ready;
  assign emit = out_valid && out_ready;

  always_comb begin
    new_op         = '0;
    new_op.v       = 1'b1;
    new_op.fn      = in_fn;
    new_op.rs1_idx = in_rs1_idx;
    new_op.rs2_idx = in_rs2_idx;
    new_op.rs1_val = in_rs1_val;
    new_op.rs2_val = in_rs2_val;
    new_op.use_imm = in_use_imm;
    new_op.imm     = in_imm;
    new_op.rd_idx  = in_rd_idx;
`ifdef EXE_ISSUE_FWD_EN
    new_op = snoop(new_op, wb_valid, wb_rd_idx, wb_data);
    main_s = snoop(main_q, wb_valid, wb_rd_idx, wb_data);
    skid_s = snoop(skid_q, wb_valid, wb_rd_idx, wb_data);
`else
    main_s = main_q;
    skid_s = skid_q;
`endif
  end

  always_comb begin
    main_d = main_s;
    skid_d = skid_s;
    if (emit) begin
      if (skid_q.v) begin
        main_d   = skid_s;
        skid_d.v = 1'b0;
      end else begin
        main_d.v = 1'b0;
      end
    end
    // in_ready implies skid is empty, so a draining main takes the new op
    if (acc) begin
      if (!main_q.v || emit) main_d = new_op;
      else                   skid_d = new_op;
    end
    if (flush) begin
      main_d.v = 1'b0;
      skid_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready  = !skid_q.v;
  assign out_valid = main_q.v;
  assign fn        = main_q.fn;
  assign in1       = main_q.rs1_val;
  assign in2       = main_q.use_imm ? main_q.imm : main_q.rs2_val;
  assign rd_idx    = main_q.rd_idx;

  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (rst) skid_q.v |-> main_q.v
  );

endmodule

// File: tb/tb_exe_issue.sv
// tb_exe_issue: table vectors, directed corner sequences and a
// queue-model random run for exe_issue.
module tb_exe_issue;
  import alufnt::*;

  localparam int RW = 5;

`ifdef EXE_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  alu_func_t     in_fn, fn;
  logic [RW-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [31:0]   in_rs1_val, in_rs2_val, in_imm;
  logic          in_use_imm;
  logic          wb_valid;
  logic [RW-1:0] wb_rd_idx, rd_idx;
  logic [31:0]   wb_data, in1, in2;
  logic          out_valid, out_ready;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exe_issue #(.REGIDX_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fn(in_fn),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rd_idx(in_rd_idx),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .fn(fn), .in1(in1), .in2(in2), .rd_idx(rd_idx)
  );

  typedef struct {
    alu_func_t     fn;
    logic [RW-1:0] r1i, r2i, rd;
    logic [31:0]   r1v, r2v, imm;
    bit            ui;
  } op_t;

  typedef struct {
    alu_func_t   fn;
    logic [31:0] a, b, res;
  } vec_t;

  vec_t vt[8];
  op_t  q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input alu_func_t f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      add:     return a + b;
      sub:     return a - b;
      sll:     return a << b[4:0];
      srl:     return a >> b[4:0];
      sra:     return 32'($signed(a) >>> b[4:0]);
      bxor:    return a ^ b;
      bor:     return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o);
    in_fn      = o.fn;
    in_rs1_idx = o.r1i;
    in_rs2_idx = o.r2i;
    in_rs1_val = o.r1v;
    in_rs2_val = o.r2v;
    in_use_imm = o.ui;
    in_imm     = o.imm;
    in_rd_idx  = o.rd;
  endtask

  function automatic op_t mk(input alu_func_t f, input logic [31:0] a,
                             input logic [31:0] b, input logic [RW-1:0] rd);
    op_t o;
    o.fn = f; o.r1i = 5'd1; o.r2i = 5'd2; o.rd = rd;
    o.r1v = a; o.r2v = b; o.imm = 32'h0; o.ui = 1'b0;
    return o;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    bit  acc, emit;

    vt[0] = '{add,  32'd3, 32'd4, 32'd7};
    vt[1] = '{sub,  32'd9, 32'd2, 32'd7};
    vt[2] = '{sll,  32'd1, 32'd5, 32'd32};
    vt[3] = '{srl,  32'd8, 32'd1, 32'd4};
    vt[4] = '{sra,  32'd6, 32'd2, 32'd1};
    vt[5] = '{bxor, 32'd5, 32'd3, 32'd6};
    vt[6] = '{bor,  32'd0, 32'd9, 32'd9};
    vt[7] = '{band, 32'd6, 32'd3, 32'd2};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd_idx = '0; wb_data = '0;
    drive(mk(sub, 32'd0, 32'd0, 5'd0));
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fn", 32'(fn), 32'(add));
    chk("rst_in1", in1, 32'd0);
    chk("rst_in2", in2, 32'd0);
    chk("rst_rd", 32'(rd_idx), 32'd0);
    rst = 1'b0;

    // single op
    out_ready = 1'b1;
    drive(mk(add, 32'd3, 32'd4, 5'd9));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_in1", in1, 32'd3);
    chk("one_in2", in2, 32'd4);
    tick();
    chk("one_gone", 32'(out_valid), 32'd0);

    // back-to-back table
    for (int i = 0; i < 8; i++) begin
      drive(mk(vt[i].fn, vt[i].a, vt[i].b, RW'(i + 1)));
      in_valid = 1'b1;
      tick();
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      chk("b2b_fn", 32'(fn), 32'(vt[i].fn));
      chk("b2b_rd", 32'(rd_idx), 32'(i + 1));
      chk("b2b_in1", in1, vt[i].a);
      chk("b2b_in2", in2, vt[i].b);
      chk("b2b_alu", alu_ref(fn, in1, in2), vt[i].res);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // stall with A, B, C
    out_ready = 1'b0;
    drive(mk(add, 32'd10, 32'd0, 5'd1)); in_valid = 1'b1;
    tick();
    chk("st_a_ready", 32'(in_ready), 32'd1);
    chk("st_a_in1", in1, 32'd10);
    drive(mk(add, 32'd11, 32'd0, 5'd2));
    tick();
    chk("st_b_ready", 32'(in_ready), 32'd0);
    chk("st_b_hold", in1, 32'd10);
    drive(mk(add, 32'd12, 32'd0, 5'd3));
    tick();
    chk("st_c_ready", 32'(in_ready), 32'd0);
    chk("st_c_hold", in1, 32'd10);
    chk("st_c_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("st_rel_b", in1, 32'd11);
    chk("st_rel_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("st_rel_c", in1, 32'd12);
    chk("st_rel_c_rd", 32'(rd_idx), 32'd3);
    tick();
    chk("st_empty", 32'(out_valid), 32'd0);

    // writeback snoop into held op
    out_ready = 1'b0;
    o = mk(add, 32'd1, 32'd0, 5'd4);
    o.r1i = 5'd5; o.r2i = 5'd0;
    drive(o); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd_idx = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    chk("fwd_in1", in1, FWD ? 32'hDEADBEEF : 32'd1);
    wb_valid = 1'b1; wb_rd_idx = 5'd0; wb_data = 32'h12345678;
    tick();
    wb_valid = 1'b0;
    chk("fwd_x0_in1", in1, FWD ? 32'hDEADBEEF : 32'd1);
    chk("fwd_x0_in2", in2, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("fwd_drain", 32'(out_valid), 32'd0);

    // immediate operand
    o = mk(add, 32'd2, 32'd7, 5'd6);
    o.ui = 1'b1; o.imm = 32'hFFFFF800;
    drive(o); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("imm_in2", in2, 32'hFFFFF800);
    tick();

    // flush with both entries full and a new op presented
    out_ready = 1'b0;
    drive(mk(add, 32'd21, 32'd0, 5'd1)); in_valid = 1'b1;
    tick();
    drive(mk(add, 32'd22, 32'd0, 5'd2));
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    drive(mk(add, 32'd23, 32'd0, 5'd3));
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_stale", 32'(out_valid), 32'd0);
    end

    // reset mid-operation
    out_ready = 1'b0;
    drive(mk(sub, 32'd31, 32'd0, 5'd1)); in_valid = 1'b1;
    tick(); tick();
    out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    chk("mrst_in1", in1, 32'd0);

    // randomized run against a queue model
    for (int c = 0; c < 600; c++) begin
      chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_fn", 32'(fn), 32'(q[0].fn));
        chk("rnd_in1", in1, q[0].r1v);
        chk("rnd_in2", in2, q[0].ui ? q[0].imm : q[0].r2v);
        chk("rnd_rd", 32'(rd_idx), 32'(q[0].rd));
      end
      o.fn  = alu_func_t'(3'($urandom_range(0, 7)));
      o.r1i = RW'($urandom_range(0, 3));
      o.r2i = RW'($urandom_range(0, 3));
      o.rd  = RW'($urandom_range(0, 31));
      o.r1v = (o.r1i == 0) ? 32'd0 : $urandom;
      o.r2v = (o.r2i == 0) ? 32'd0 : $urandom;
      o.imm = $urandom;
      o.ui  = 1'($urandom_range(0, 1));
      drive(o);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 30) == 0);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_rd_idx = RW'($urandom_range(0, 3));
      wb_data   = $urandom;
      acc  = in_valid && (q.size() < 2);
      emit = out_ready && (q.size() > 0);
      if (FWD && wb_valid && wb_rd_idx != 0) begin
        foreach (q[k]) begin
          if (q[k].r1i == wb_rd_idx) q[k].r1v = wb_data;
          if (q[k].r2i == wb_rd_idx) q[k].r2v = wb_data;
        end
        if (o.r1i == wb_rd_idx) o.r1v = wb_data;
        if (o.r2i == wb_rd_idx) o.r2v = wb_data;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (emit) void'(q.pop_front());
        if (acc) q.push_back(o);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
